nibble_serial_addsub: RTL and testbench



---
 rtl/nibble_serial_addsub_if.sv | 27 ++
 rtl/nibble_serial_addsub.sv | 128 ++++++++++++
 tb/tb_nibble_serial_addsub.sv | 137 +++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_if.sv
// Handshake bundle for the nibble-serial add/subtract unit.
// The request side carries the operands; the response side carries the result and flags.
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, carry, zero, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, carry, zero, overflow
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract built around one 4-bit adder stage.
// Processes one nibble per cycle, LSB first, and then holds the result until the consumer accepts it.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_serial_addsub_if.slave  bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    // b is stored already inverted for subtract, so the adder never sees sub again.
    logic [WIDTH-1:0]   bx_reg, bx_next;
    logic               cin_reg, cin_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               zacc_reg, zacc_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               carry_reg, carry_next;
    logic               zero_reg, zero_next;
    logic               overflow_reg, overflow_next;

    logic [3:0] a_nib [NIB];
    logic [3:0] b_nib [NIB];
    logic [4:0] nib_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = bx_reg[4*gi +: 4];
        end
    endgenerate

    assign nib_sum = {1'b0, a_nib[cnt_reg]} + {1'b0, b_nib[cnt_reg]} + {4'b0000, cin_reg};

    always_comb begin
        state_next    = state_reg;
        a_next        = a_reg;
        bx_next       = bx_reg;
        cin_next      = cin_reg;
        cnt_next      = cnt_reg;
        zacc_next     = zacc_reg;
        result_next   = result_reg;
        carry_next    = carry_reg;
        zero_next     = zero_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next     = bus.a;
                    bx_next    = bus.b ^ {WIDTH{bus.sub}};
                    cin_next   = bus.sub;
                    cnt_next   = '0;
                    zacc_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                result_next[4*cnt_reg +: 4] = nib_sum[3:0];
                cin_next  = nib_sum[4];
                zacc_next = zacc_reg & (nib_sum[3:0] == 4'h0);
                if (cnt_reg == LAST) begin
                    // Flags settle only on the final nibble so they are stable through DONE.
                    carry_next    = nib_sum[4];
                    zero_next     = zacc_reg & (nib_sum[3:0] == 4'h0);
                    overflow_next = (a_reg[WIDTH-1] == bx_reg[WIDTH-1]) &&
                                    (nib_sum[3] != a_reg[WIDTH-1]);
                    state_next    = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            bx_reg       <= '0;
            cin_reg      <= 1'b0;
            cnt_reg      <= '0;
            zacc_reg     <= 1'b0;
            result_reg   <= '0;
            carry_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_reg        <= a_next;
            bx_reg       <= bx_next;
            cin_reg      <= cin_next;
            cnt_reg      <= cnt_next;
            zacc_reg     <= zacc_next;
            result_reg   <= result_next;
            carry_reg    <= carry_next;
            zero_reg     <= zero_next;
            overflow_reg <= overflow_next;
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.carry     = carry_reg;
    assign bus.zero      = zero_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub at WIDTH=16 with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_nibble_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    nibble_serial_addsub_if #(.WIDTH(16)) bus ();

    nibble_serial_addsub #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a falling edge in IDLE, wait for DONE, check, then retire it.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic [15:0] er, input logic ec,
                          input logic ez, input logic ev);
        bus.a = av;
        bus.b = bv;
        bus.sub = sv;
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, 32'd4);
        chk({tag, ".result"}, {16'b0, bus.result}, {16'b0, er});
        chk({tag, ".carry"}, {31'b0, bus.carry}, {31'b0, ec});
        chk({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, ez});
        chk({tag, ".overflow"}, {31'b0, bus.overflow}, {31'b0, ev});
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".out_valid_after"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, ".in_ready_after"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("reset.out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset.result", {16'b0, bus.result}, 32'd0);
        chk("reset.flags", {29'b0, bus.carry, bus.zero, bus.overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_plain",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        run_op("sub_zero",   16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("sub_borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // Backpressure: hold DONE for 5 cycles while a new request is offered.
        bus.a = 16'h0F0F; bus.b = 16'h0101; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp.enter_done", {31'b0, bus.out_valid}, 32'd1);
        bus.a = 16'hAAAA; bus.b = 16'h5555; bus.sub = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.hold", {11'b0, bus.out_valid, bus.in_ready, bus.carry, bus.zero,
                            bus.overflow, bus.result}, {11'b0, 5'b10000, 16'h1010});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp.in_ready_after", {31'b0, bus.in_ready}, 32'd1);
        chk("bp.not_accepted", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("bp.still_idle", {31'b0, bus.in_ready}, 32'd1);

        // Operand stability: inputs change right after the accept edge.
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.sub = 1'b1;
        repeat (4) @(negedge clk);
        chk("stable.out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("stable.result", {16'b0, bus.result}, 32'h3333);
        chk("stable.flags", {29'b0, bus.carry, bus.zero, bus.overflow}, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset during the second RUN cycle discards the operation.
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_mid.out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_mid.result", {16'b0, bus.result}, 32'd0);
        chk("rst_mid.flags", {29'b0, bus.carry, bus.zero, bus.overflow}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid.stays_idle", {31'b0, bus.out_valid}, 32'd0);
        run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
